conv_row_feeder: RTL

Front-end producer for the 1-D convolution engine. It accepts a byte-serial signed pixel stream over a valid/ready handshake and packs each group of 32 pixels into a 256-bit row. It presents the row to the engine with a one-cycle `conv_start` pulse and holds the row stable until the engine returns `conv_done`. Two row buffers (ping-pong) let the next row be packed while the engine is busy with the current one.

---
 rtl/conv_row_feeder_if.sv | 29 ++
 rtl/conv_row_feeder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/conv_row_feeder_if.sv
// Bus bundle between the pixel source, the row feeder and the convolution engine.
//
// Pixel stream handshake: a pixel moves on every rising clk edge where s_valid
// and s_ready are both high. The source holds s_data stable while s_valid is
// high. s_ready never depends on s_valid in the same cycle. The engine side is
// a start/done pulse pair rather than a valid/ready pair.
interface conv_row_feeder_if #(
    parameter int ROW_PIXELS = 32,
    parameter int PIX_W      = 8
);
    logic                          s_valid;
    logic                          s_ready;
    logic [PIX_W-1:0]              s_data;
    logic                          conv_start;
    logic [ROW_PIXELS*PIX_W-1:0]   conv_row;
    logic                          conv_done;

    // Environment view: pixel source plus convolution engine.
    modport master (
        output s_valid, s_data, conv_done,
        input  s_ready, conv_start, conv_row
    );

    // Feeder view.
    modport slave (
        input  s_valid, s_data, conv_done,
        output s_ready, conv_start, conv_row
    );
endinterface

// File: rtl/conv_row_feeder.sv
// Packs a byte-serial pixel stream into rows and hands each row to the
// convolution engine. Two ping-pong buffers allow one row to be filled while the
// engine works on the other. Rows are issued strictly in arrival order.
module conv_row_feeder #(
    parameter int ROW_PIXELS = 32,
    parameter int PIX_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    conv_row_feeder_if.slave    bus,
    output logic                busy,
    output logic [15:0]         rows_issued,
    output logic                err_spurious_done,
    output logic                state_dbg
);
    localparam int ROW_W = ROW_PIXELS * PIX_W;
    localparam int CNT_W = $clog2(ROW_PIXELS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ROW_W-1:0]   buf_q [0:1];
    logic [1:0]         full_q;
    logic               wr_sel_q;
    logic               rd_sel_q;
    logic [CNT_W-1:0]   fill_cnt_q;

    logic               accept;
    logic               row_last;
    logic               start_d;
    logic               done_ok;
    logic               spurious;

    // Write side only looks at registered state, so s_ready never combinationally
    // follows s_valid or conv_done.
    assign bus.s_ready = !full_q[wr_sel_q];
    assign accept      = bus.s_valid && bus.s_ready;
    assign row_last    = accept && (fill_cnt_q == CNT_W'(ROW_PIXELS - 1));

    // The engine always sees the oldest full buffer; it cannot move while in WAIT.
    assign bus.conv_row = buf_q[rd_sel_q];
    assign busy         = (state_q == ST_WAIT);
    assign state_dbg    = state_q;

    // Pixel packing into the buffer selected by the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (accept) begin
            buf_q[wr_sel_q][fill_cnt_q*PIX_W +: PIX_W] <= bus.s_data;
        end
    end

    // Write pointer, fill count and full flags. A completing row and a returning
    // conv_done always target different buffers, so both updates can land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            fill_cnt_q <= '0;
        end else begin
            if (accept) begin
                fill_cnt_q <= row_last ? '0 : fill_cnt_q + 1'b1;
            end
            if (row_last) begin
                full_q[wr_sel_q] <= 1'b1;
                wr_sel_q         <= !wr_sel_q;
            end
            if (done_ok) begin
                full_q[rd_sel_q] <= 1'b0;
            end
        end
    end

    // Issue FSM next-state and decode: IDLE issues a full buffer, WAIT holds it.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        done_ok  = 1'b0;
        spurious = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_sel_q]) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end
                if (bus.conv_done) begin
                    spurious = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.conv_done) begin
                    done_ok = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue FSM registers: state, start pulse, read pointer and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            bus.conv_start    <= 1'b0;
            rd_sel_q          <= 1'b0;
            rows_issued       <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            state_q        <= state_d;
            bus.conv_start <= start_d;
            if (start_d) begin
                rows_issued <= rows_issued + 16'd1;
            end
            if (done_ok) begin
                rd_sel_q <= !rd_sel_q;
            end
            if (spurious) begin
                err_spurious_done <= 1'b1;
            end
        end
    end
endmodule
